// File: rtl/ysyx_22041211_imm_ext_pipe.sv
// RV32I/RV64I immediate extractor/extender with a registered valid/ready output
// stage and a one-entry skid buffer; an opaque tag travels with each beat.
module ysyx_22041211_imm_ext_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if ((XLEN != 32) && (XLEN != 64)) begin : gen_bad_xlen
    $error("ysyx_22041211_imm_ext_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : gen_bad_tag_w
    $error("ysyx_22041211_imm_ext_pipe: TAG_W must be at least 1");
  end

  typedef enum logic [2:0] {
    FmtI = 3'b000,
    FmtS = 3'b001,
    FmtB = 3'b010,
    FmtU = 3'b011,
    FmtJ = 3'b100,
    FmtZ = 3'b101
  } fmt_e;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_inst[6:0];

  always_comb begin
    imm32   = '0;
    dec_err = 1'b0;
    unique case (in_type)
      FmtI:    imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FmtS:    imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FmtB:    imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      FmtU:    imm32 = {in_inst[31:12], 12'b0};
      FmtJ:    imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      FmtZ:    imm32 = {27'b0, in_inst[19:15]};
      default: dec_err = 1'b1;
    endcase
    // Every 32-bit form is already correctly signed in bit 31 (Z and illegal give 0).
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;

  logic in_fire;
  logic out_free;

  assign in_ready = !rst && !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (out_free) begin
      // A full skid means in_ready was low, so no new beat competes with it.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_tag_d   = in_tag;
        out_err_d   = dec_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_err_d   = dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ysyx_22041211_imm_ext_pipe.sv
// Directed and randomized bench for the immediate extender: XLEN=32 and XLEN=64
// instances share one input stream.
module tb_ysyx_22041211_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_type;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22041211_imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
  );

  ysyx_22041211_imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
    .in_type(in_type), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t);
    logic signed [63:0] v;
    case (t)
      3'd0:    v = $signed(w[31:20]);
      3'd1:    v = $signed({w[31:25], w[11:7]});
      3'd2:    v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      3'd3:    v = $signed({w[31:12], 12'h000});
      3'd4:    v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      3'd5:    v = {59'd0, w[19:15]};
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_type = '0; in_tag = '0; out_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (in_ready32 !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready32);
    end
    n_checks++;
    if ({out_valid32, out_imm32, out_tag32, out_err32} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs32: got v=%b imm=%h tag=%h err=%b want all 0",
               out_valid32, out_imm32, out_tag32, out_err32);
    end
    n_checks++;
    if ({out_valid64, out_imm64, out_tag64, out_err64} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_outputs64: got v=%b imm=%h tag=%h err=%b want all 0",
               out_valid64, out_imm64, out_tag64, out_err64);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %b/%b want 1/1", in_ready32, in_ready64);
    end
  endtask

  // One beat with out_ready=1: visible the cycle after acceptance, gone the cycle after.
  task automatic send_beat(input string name, input logic [31:0] inst, input logic [2:0] typ,
                           input logic [4:0] tag, input logic [63:0] exp64, input logic exp_err);
    in_valid = 1'b1; in_inst = inst; in_type = typ; in_tag = tag; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_inst = 32'hDEAD_BEEF; in_type = 3'd7; in_tag = 5'h1F;
    n_checks++;
    if (out_valid32 !== 1'b1 || out_imm32 !== exp64[31:0] || out_err32 !== exp_err ||
        out_tag32 !== tag) begin
      n_fail++;
      $display("FAIL %s_x32: got v=%b imm=%h err=%b tag=%0d want v=1 imm=%h err=%b tag=%0d",
               name, out_valid32, out_imm32, out_err32, out_tag32, exp64[31:0], exp_err, tag);
    end
    n_checks++;
    if (out_valid64 !== 1'b1 || out_imm64 !== exp64 || out_err64 !== exp_err) begin
      n_fail++;
      $display("FAIL %s_x64: got v=%b imm=%h err=%b want v=1 imm=%h err=%b",
               name, out_valid64, out_imm64, out_err64, exp64, exp_err);
    end
    step();
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++; $display("FAIL %s_drained: got out_valid=%b want 0", name, out_valid32);
    end
  endtask

  task automatic test_formats();
    send_beat("fmt_i",   32'hFFF00093, 3'd0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat("fmt_s",   32'hFE112E23, 3'd1, 5'd2,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_beat("fmt_b",   32'hFE000CE3, 3'd2, 5'd3,  64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    send_beat("fmt_u",   32'h800002B7, 3'd3, 5'd4,  64'hFFFF_FFFF_8000_0000, 1'b0);
    send_beat("fmt_jp",  32'h0080006F, 3'd4, 5'd5,  64'h0000_0000_0000_0008, 1'b0);
    send_beat("fmt_jn",  32'hFFDFF06F, 3'd4, 5'd6,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_beat("fmt_z",   32'hFFFFD073, 3'd5, 5'd7,  64'h0000_0000_0000_001F, 1'b0);
    send_beat("fmt_zi",  32'hFFFFD073, 3'd0, 5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat("fmt_110", 32'hFFFFFFFF, 3'd6, 5'd9,  64'd0,                   1'b1);
    send_beat("fmt_111", 32'hFFFFFFFF, 3'd7, 5'd23, 64'd0,                   1'b1);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 3'd0; in_inst = 32'h00100013; in_tag = 5'd1;
    step();
    n_checks++;
    if (out_tag32 !== 5'd1 || out_valid32 !== 1'b1 || in_ready32 !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: got v=%b tag=%0d rdy=%b want 1/1/1",
                         out_valid32, out_tag32, in_ready32);
    end
    in_inst = 32'h00200013; in_tag = 5'd2;
    step();
    n_checks++;
    if (in_ready32 !== 1'b0 || out_tag32 !== 5'd1) begin
      n_fail++; $display("FAIL bp_skid_full: got rdy=%b tag=%0d want 0/1", in_ready32, out_tag32);
    end
    in_inst = 32'h00300013; in_tag = 5'd3;
    step();
    step();
    n_checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || out_tag32 !== 5'd1 ||
        out_imm32 !== 32'd1) begin
      n_fail++; $display("FAIL bp_hold: got rdy=%b v=%b tag=%0d imm=%h want 0/1/1/00000001",
                         in_ready32, out_valid32, out_tag32, out_imm32);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 5'd2 || out_imm32 !== 32'd2 ||
        in_ready32 !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain2: got v=%b tag=%0d imm=%h rdy=%b want 1/2/00000002/1",
                         out_valid32, out_tag32, out_imm32, in_ready32);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 5'd3 || out_imm32 !== 32'd3) begin
      n_fail++; $display("FAIL bp_drain3: got v=%b tag=%0d imm=%h want 1/3/00000003",
                         out_valid32, out_tag32, out_imm32);
    end
    step();
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: got out_valid=%b want 0", out_valid32);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_type = 3'd0; in_tag = 5'(k);
      in_inst = {12'(k * 3), 20'h00013};
      step();
      n_checks++;
      if (out_valid32 !== 1'b1 || out_tag32 !== 5'(k) || out_imm32 !== 32'(k * 3)) begin
        n_fail++; $display("FAIL stream_%0d: got v=%b tag=%0d imm=%h want 1/%0d/%h",
                           k, out_valid32, out_tag32, out_imm32, k, 32'(k * 3));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [4:0]  tq[$];
    logic [31:0] iq[$];
    logic [63:0] xq[$];
    logic        eq[$];
    logic [63:0] e;
    for (int c = 0; c < 400; c++) begin
      n_checks++;
      if (out_valid32 !== (tq.size() != 0) || in_ready32 !== (tq.size() < 2)) begin
        n_fail++; $display("FAIL rand_state_c%0d: got v=%b rdy=%b want v=%b rdy=%b", c,
                           out_valid32, in_ready32, tq.size() != 0, tq.size() < 2);
      end
      if (c < 380) begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      in_inst = $urandom; in_type = 3'($urandom_range(0, 7)); in_tag = 5'($urandom);
      if (out_valid32 && out_ready) begin
        n_checks++;
        if (tq.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious_c%0d: got tag=%0d want no beat", c, out_tag32);
        end else begin
          if (out_tag32 !== tq[0] || out_imm32 !== iq[0] || out_err32 !== eq[0] ||
              out_imm64 !== xq[0]) begin
            n_fail++;
            $display("FAIL rand_beat_c%0d: got tag=%0d imm=%h/%h err=%b want %0d %h/%h %b", c,
                     out_tag32, out_imm32, out_imm64, out_err32, tq[0], iq[0], xq[0], eq[0]);
          end
          void'(tq.pop_front()); void'(iq.pop_front());
          void'(xq.pop_front()); void'(eq.pop_front());
        end
      end
      if (in_valid && in_ready32) begin
        e = ref_imm(in_inst, in_type);
        tq.push_back(in_tag); iq.push_back(e[31:0]); xq.push_back(e);
        eq.push_back(in_type > 3'd5);
      end
      step();
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 3'd0; in_inst = 32'h01100013; in_tag = 5'd17;
    step();
    in_inst = 32'h01200013; in_tag = 5'd18;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_setup: got v=%b rdy=%b want 1/0", out_valid32, in_ready32);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_rdy_in_rst: got %b want 0", in_ready32);
    end
    step();
    rst = 1'b0;
    n_checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b/%b want 0/0", out_valid32, out_valid64);
    end
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++; $display("FAIL flush_rdy_after: got %b want 1", in_ready32);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_fail++; $display("FAIL flush_ghost_%0d: got v=%b tag=%0d want v=0",
                           k, out_valid32, out_tag32);
      end
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_imm_ext_pipe.md
Name: ysyx_22041211_imm_ext_pipe

Overview:
Parametrised, pipelined immediate extractor and extender for the RV32I/RV64I decode path. It selects the immediate format from a 32-bit instruction, then sign- or zero-extends it to XLEN. The result is registered behind a valid/ready handshake with a one-entry skid buffer, so decode can stall against execute without losing beats. An opaque tag (for example rd or ROB index) travels with each beat.

Parameters:
XLEN, 32, datapath width of the extended immediate; legal values are 32 and 64 only, and any other value is an elaboration error.
TAG_W, 5, width of the sideband tag carried alongside each beat; minimum 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  the input beat is valid.
in_ready  output  1  the block can accept a beat this cycle.
in_inst  input  32  raw instruction word.
in_type  input  3  immediate format select.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  the output beat is valid.
out_ready  input  1  the consumer accepts the output beat.
out_imm  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag of the output beat.
out_err  output  1  in_type was illegal for this beat.

Behaviour:
- Reset is synchronous and active-high.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_err=0; skid buffer empty.
- in_ready = !rst && !skid_valid. It is low during any reset cycle and high on the first cycle after reset.
- Input handshake: a beat transfers when in_valid && in_ready. Output handshake: a beat transfers when out_valid && out_ready.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1 when the output register is free or draining.
- Format decode, with i = in_inst and sext() meaning sign-extend to XLEN:
  - 000 I: sext(i[31:20]).
  - 001 S: sext({i[31:25], i[11:7]}).
  - 010 B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - 011 U: sext({i[31:12], 12'b0}); for XLEN=64, bit 31 fills bits 63:32.
  - 100 J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - 101 Z (CSR zimm): zero-extend i[19:15].
  - 110 and 111: imm=0, err=1. The beat still flows through the pipeline and is not dropped.
- Decode is combinational ahead of the register. Immediate, tag and err are captured together as one payload.
- Output register update:
  - If the output register is empty, or holds a beat being consumed this cycle, it loads the skid buffer when the skid is full, otherwise the incoming beat.
  - If the output register is held (out_valid && !out_ready) and a beat is accepted, the beat goes into the skid buffer.
- Skid buffer:
  - It empties into the output register in the cycle that output beat is consumed.
  - An input beat cannot arrive in that same cycle, because in_ready was low while the skid was full.
- Ordering is strictly FIFO. There is no beat loss or duplication, and at most 2 beats are in flight.
- Simultaneous accept and consume with the skid empty: the output register takes the new beat and out_valid stays 1. Sustained throughput is 1 beat/cycle when out_ready=1.
- out_* are held stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight beats are discarded, and out_valid is 0 on the cycle after the reset edge.
- Input payload is ignored when no transfer occurs.

Test Plan:
1. Single beats with out_ready=1, XLEN=32, each checking 1-cycle latency:
   - 0xFFF00093, type I → out_imm=0xFFFFFFFF, err=0.
   - 0xFE112E23, type S → out_imm=0xFFFFFFFC.
2. More formats, XLEN=32:
   - 0xFE000CE3, type B → out_imm=0xFFFFFFF8.
   - 0x800002B7, type U → out_imm=0x80000000.
   - Same U beat with XLEN=64 → out_imm=0xFFFFFFFF80000000.
3. Zero-extension: 0xFFFFD073, type Z → out_imm=0x0000001F. The same word as type I → out_imm=0xFFFFFFFF.
4. Backpressure:
   - Stimulus: out_ready=0 while 3 beats with tags 1, 2, 3 are offered back-to-back.
   - Acceptance: tags 1 and 2 are accepted, then in_ready=0 and tag 3 is held by the source.
   - Drain: raise out_ready; out_tag sequence is 1, 2, 3 with no gaps after the first, and in_ready returns to 1 one cycle after the skid drains.
5. Streaming: 16 consecutive beats with in_valid=1 and out_ready=1 → 16 outputs in 16 consecutive cycles, in order. A randomized out_ready version must match a reference queue model.
6. Illegal type and reset:
   - Type 111 → out_imm=0, out_err=1, tag preserved.
   - With 2 beats buffered, assert rst for 1 cycle → out_valid=0 on the next cycle and in_ready=1 on the cycle after rst deasserts; neither buffered beat ever appears.
